rr_reg_arbiter: RTL
===================

RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the register, range 2..8.
REQ-002 Parameter W, default 8: register and per-requester data width.
REQ-003 Parameter MAX_LOCK, default 4: maximum consecutive grants to one locked requester, range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low: state resets at a rising clk edge while rst==0.
REQ-006 req  input  N  per-requester write request, level-sensitive.
REQ-007 lock  input  N  per-requester request to keep the grant on following cycles.
REQ-008 wdata  input  N*W  write data; requester i occupies bits [i*W +: W].
REQ-009 gnt  output  N  registered one-hot grant: the requester whose data was captured at the last edge, or all-zero.
REQ-010 q  output  W  shared register contents.
REQ-011 q_valid  output  1  high once q has been written at least once since reset.
REQ-012 owner  output  $clog2(N)  index of the last writer; holds its value while idle.
REQ-013 update  output  1  one-cycle pulse, high in the cycle after each edge at which q was written.

Function
REQ-014 At each edge with any req bit high and rst==1, exactly one requester shall be selected; q<=its wdata, gnt<=its one-hot, owner<=its index, update<=1, q_valid<=1.
REQ-015 At an edge with req all-zero, gnt<=0 and update<=0; q, owner and q_valid shall hold.
REQ-016 Latency from req sampled to gnt/q visible shall be exactly 1 cycle; there shall be no combinational path from req to gnt.
REQ-017 Selection shall be round-robin: search starts at index (last granted + 1) mod N and wraps to 0; after reset the search starts at index 0.
REQ-018 The FSM shall have three states:
  - IDLE: no grant last edge.
  - GRANT: unlocked grant last edge.
  - LOCKED: current owner had req&lock at the last grant.
REQ-019 IDLE/GRANT -> LOCKED when the winner has lock high; -> GRANT when the winner has lock low; -> IDLE when no req.
REQ-020 In LOCKED, while owner keeps req&lock and lock_cnt<MAX_LOCK, the owner shall be re-granted regardless of other requests, and lock_cnt shall increment.
REQ-021 lock_cnt shall be 4 bits, set to 1 on entry to LOCKED, and shall never wrap.
REQ-022 In LOCKED, if lock_cnt==MAX_LOCK and any other requester is pending, the grant shall go round-robin to the next requester, excluding the owner.
REQ-023 If no other requester is pending in the case of REQ-022, the owner may be re-granted, with lock_cnt held at MAX_LOCK.
REQ-024 In LOCKED, if the owner drops req or lock, the next edge shall arbitrate round-robin from owner+1, with the FSM following REQ-019.
REQ-025 A single requester holding req continuously without lock shall be granted every cycle; fairness applies only when more than one requester is pending.
REQ-026 lock bits without the matching req bit shall be ignored.

Reset
REQ-027 On reset: q=0, q_valid=0, gnt=0, owner=0, update=0, state=IDLE, lock_cnt=0, round-robin pointer=0.
REQ-028 Reset asserted mid-lock shall abort the lock with no write at that edge; arbitration shall resume from index 0 at the first edge with rst==1.

Structure
REQ-029 A shared package rr_arb_pkg shall hold the FSM state enum (IDLE, GRANT, LOCKED) and the default constants for N, W and MAX_LOCK.
REQ-030 The round-robin selector shall be one combinational sub-module, rr_pick, with inputs request vector and start index and outputs found and index; it shall also be used for the lock-expiry exclusion.

Verification
REQ-031 Reset with rst=0 for 2 edges while req=4'b1111 -> q=0, gnt=0, q_valid=0, update=0 throughout.
REQ-032 req=4'b1111, lock=0, wdata[i]=8'hA0+i held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001..., q follows A0,A1,A2,A3,A0, update=1 every cycle.
REQ-033 req=4'b0101, lock=4'b0001, MAX_LOCK=4 -> gnt=0001 for 4 cycles, then 0100, then 0001 again; q shows wdata[0] for 4 cycles, then wdata[2].
REQ-034 Single req=4'b1000 with wdata=8'h5C for 1 cycle, then req=0 -> gnt=1000 and update=1 for one cycle, then gnt=0 and update=0; q=5C, owner=3 and q_valid=1 hold.
REQ-035 Locked owner 1 holding the grant when rst=0 for one edge -> that edge gives q=0 and state IDLE; with req=4'b0010 at the next edge -> gnt=0010, lock_cnt=1.
REQ-036 Self-checking: a reference model of round-robin plus lock drives an assertion each cycle on gnt one-hot-or-zero, q, owner and update.

Source files
------------

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb_pkg : shared types and defaults for the round-robin register arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_LOCK = 4;
  localparam int LOCK_CNT_W   = 4;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin search starting at start_i, wrapping to 0
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Walk the search order backwards so the earliest hit is the last one assigned.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(start_i) + k) % N);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_reg_arbiter : N writers share one register, round-robin with bounded lock
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  output logic [$clog2(N)-1:0] owner,
  output logic                 update
);

  localparam int IW = $clog2(N);
  localparam logic [LOCK_CNT_W-1:0] MAX_CNT = LOCK_CNT_W'(MAX_LOCK);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [N-1:0]          gnt_q, gnt_d;
  logic [W-1:0]          q_q, q_d;
  logic                  valid_q, valid_d;
  logic                  update_q, update_d;

  logic [W-1:0]  wd [N];
  logic          rr_found, ex_found;
  logic [IW-1:0] rr_idx, ex_idx;
  logic [N-1:0]  ex_req;
  logic          own_hold;
  logic          win_valid;
  logic [IW-1:0] win_idx;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign wd[i] = wdata[i*W +: W];
  end

  assign ex_req   = req & ~(ONE << owner_q);
  assign own_hold = req[owner_q] & lock[owner_q];

  rr_pick #(.N(N)) u_pick_rr (
    .req_i   (req),
    .start_i (ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  // Lock expiry: same search from owner+1, with the owner masked out.
  rr_pick #(.N(N)) u_pick_ex (
    .req_i   (ex_req),
    .start_i (ptr_q),
    .found_o (ex_found),
    .idx_o   (ex_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    win_valid  = 1'b0;
    win_idx    = '0;
    if (state_q == LOCKED && own_hold && (lock_cnt_q < MAX_CNT || !ex_found)) begin
      // Owner keeps the grant; the count saturates at MAX_CNT when nobody else waits.
      win_valid = 1'b1;
      win_idx   = owner_q;
      state_d   = LOCKED;
      if (lock_cnt_q < MAX_CNT) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end else if ((state_q == LOCKED && own_hold) ? ex_found : rr_found) begin
      win_valid = 1'b1;
      win_idx   = (state_q == LOCKED && own_hold) ? ex_idx : rr_idx;
      if (lock[win_idx]) begin
        state_d    = LOCKED;
        lock_cnt_d = LOCK_CNT_W'(1);
      end else begin
        state_d    = GRANT;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    gnt_d    = win_valid ? (ONE << win_idx) : '0;
    q_d      = win_valid ? wd[win_idx] : q_q;
    owner_d  = win_valid ? win_idx : owner_q;
    ptr_d    = win_valid ? IW'(wrap_inc(int'(win_idx), N)) : ptr_q;
    valid_d  = valid_q | win_valid;
    update_d = win_valid;
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = valid_q;
  assign owner   = owner_q;
  assign update  = update_q;

endmodule
`default_nettype wire
